// File: rtl/serializer.sv
// Parallel-to-serial transmitter for the AudioNet frame link: one-word holding buffer,
// MSB-first shift-out, periodic frame sync and idle-word insertion on underrun.
module serializer #(
    parameter int unsigned           FRAME_BITS = 256,
    parameter logic [FRAME_BITS-1:0] IDLE_WORD  = '0
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  pvalid,
    input  logic [FRAME_BITS-1:0] pdata,
    output logic                  pready,
    output logic                  sdata,
    output logic                  sfs,
    output logic                  underrun,
    output logic                  busy
);

    localparam int unsigned     CntW  = $clog2(FRAME_BITS);
    localparam logic [CntW-1:0] LastK = CntW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {StIdle, StSync, StRun} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [FRAME_BITS-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  sdata_q, sdata_d;
    logic                  sfs_q, sfs_d;
    logic                  underrun_q, underrun_d;
    logic                  accept;
    logic                  boundary;
    logic                  do_load;
    logic [FRAME_BITS-1:0] load_word;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sdata_d     = 1'b0;
        sfs_d       = 1'b0;
        underrun_d  = 1'b0;
        load_word   = IDLE_WORD;

        accept   = pvalid && !hold_full_q;
        boundary = (state_q == StSync) || ((state_q == StRun) && (cnt_q == LastK));
        // SYNC always proceeds to RUN; in RUN, en decides between loading and stopping.
        do_load  = boundary && ((state_q == StSync) || en);

        // An accept on a loading boundary bypasses the hold buffer.
        if (accept && !do_load) begin
            hold_d      = pdata;
            hold_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StSync;
                    sfs_d   = 1'b1;
                end
            end
            StSync, StRun: begin
                if (do_load) begin
                    if (hold_full_q) begin
                        load_word   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (pvalid) begin
                        load_word = pdata;
                    end else begin
                        underrun_d = 1'b1;
                    end
                    state_d = StRun;
                    cnt_d   = '0;
                    sdata_d = load_word[FRAME_BITS-1];
                    shreg_d = {load_word[FRAME_BITS-2:0], 1'b0};
                end else if (boundary) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    sdata_d = shreg_q[FRAME_BITS-1];
                    shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    sfs_d   = (cnt_d == LastK);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sdata_q     <= 1'b0;
            sfs_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sdata_q     <= sdata_d;
            sfs_q       <= sfs_d;
            underrun_q  <= underrun_d;
        end
    end

    assign pready   = !hold_full_q;
    assign sdata    = sdata_q;
    assign sfs      = sfs_q;
    assign underrun = underrun_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_serializer.sv
// Randomized scoreboard bench for serializer: a frame-level model predicts the word stream,
// an independent receiver monitor deserializes sdata/sfs and checks against it.
module tb_serializer;

    localparam int unsigned FB = 256;
    localparam logic [FB-1:0] IDLE = '0;

    logic          sclk = 1'b0;
    logic          rstn = 1'b1;
    logic          en = 1'b0;
    logic          pvalid = 1'b0;
    logic [FB-1:0] pdata = '0;
    logic          pready, sdata, sfs, underrun, busy;

    serializer #(.FRAME_BITS(FB), .IDLE_WORD(IDLE)) dut (
        .sclk(sclk), .rstn(rstn), .en(en), .pvalid(pvalid), .pdata(pdata),
        .pready(pready), .sdata(sdata), .sfs(sfs), .underrun(underrun), .busy(busy)
    );

    always #5 sclk = ~sclk;

    typedef struct { logic [FB-1:0] w; bit und; } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int errors  = 0;

    // Model: phase of the link, position within frame, words accepted but not yet framed.
    localparam int MIdle = 0, MSync = 1, MRun = 2;
    int            mst = MIdle;
    int            k = 0;
    logic [FB-1:0] pend[$];

    function automatic logic [FB-1:0] rand_word();
        logic [FB-1:0] w;
        for (int i = 0; i < FB / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic frame_start(input bit acc, input logic [FB-1:0] pd);
        exp_t e;
        if (pend.size() > 0) begin
            e.w = pend.pop_front(); e.und = 1'b0;
        end else if (acc) begin
            e.w = pd; e.und = 1'b0;
        end else begin
            e.w = IDLE; e.und = 1'b1;
        end
        exp_q.push_back(e);
        mst = MRun;
        k = 0;
    endtask

    // One clock: check handshake/busy, drive inputs, advance the model across the next edge.
    task automatic step(input bit e, input bit pv, input logic [FB-1:0] pd, output bit acc);
        @(negedge sclk);
        vectors++;
        if (pready !== (pend.size() == 0))
            $display("FAIL pready t=%0t got=%b exp=%b", $time, pready, pend.size() == 0);
        vectors++;
        if (busy !== (mst != MIdle))
            $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, mst != MIdle);
        if (pready !== (pend.size() == 0) || busy !== (mst != MIdle)) errors++;
        en = e; pvalid = pv; pdata = pd;
        acc = pv && (pend.size() == 0);
        if (mst == MIdle) begin
            if (acc) pend.push_back(pd);
            if (e) mst = MSync;
        end else if (mst == MSync) begin
            frame_start(acc, pd);
        end else if (k == FB - 1) begin
            if (e) frame_start(acc, pd);
            else begin
                mst = MIdle;
                if (acc) pend.push_back(pd);
            end
        end else begin
            k++;
            if (acc) pend.push_back(pd);
        end
    endtask

    task automatic run(input bit e, input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(e, 1'b0, '0, acc);
    endtask

    task automatic offer(input bit e, input logic [FB-1:0] w);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 2 * FB + 4) begin
            step(e, 1'b1, w, acc);
            n++;
        end
        vectors++;
        if (!acc) begin
            errors++;
            $display("FAIL offer_timeout got=not_accepted exp=accepted");
        end
    endtask

    task automatic wait_k(input bit e, input int target);
        int n = 0;
        while (!(mst == MRun && k == target) && n < 2 * FB + 4) begin
            run(e, 1);
            n++;
        end
    endtask

    task automatic stop_link();
        int n = 0;
        while (mst != MIdle && n < FB + 4) begin
            run(1'b0, 1);
            n++;
        end
        vectors++;
        if (mst != MIdle) begin
            errors++;
            $display("FAIL stop_timeout got=running exp=idle");
        end
    endtask

    task automatic check_reset_outs(input string tag);
        vectors++;
        if (sdata !== 1'b0 || sfs !== 1'b0 || pready !== 1'b1 || underrun !== 1'b0 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL %s got sdata=%b sfs=%b pready=%b underrun=%b busy=%b exp 0 0 1 0 0",
                     tag, sdata, sfs, pready, underrun, busy);
        end
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rstn = 1'b0; en = 1'b0; pvalid = 1'b0;
        #1;
        check_reset_outs("midframe_reset");
        if (mst == MRun) void'(exp_q.pop_back());
        mst = MIdle;
        k = 0;
        pend.delete();
        repeat (2) @(negedge sclk);
        rstn = 1'b1;
    endtask

    // Receiver: SYNC pulse opens a stream, each later sfs closes a FB-bit frame.
    initial begin : monitor
        bit            in_frame = 1'b0;
        int            cnt = 0;
        logic [FB-1:0] word = '0;
        bit            und_first = 1'b0;
        bit            und_extra = 1'b0;
        exp_t          e;
        forever begin
            @(negedge sclk);
            if (!rstn) begin
                in_frame = 1'b0;
            end else if (!busy) begin
                in_frame = 1'b0;
                vectors++;
                if (sdata !== 1'b0 || sfs !== 1'b0 || underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs t=%0t got sdata=%b sfs=%b underrun=%b exp 0 0 0",
                             $time, sdata, sfs, underrun);
                end
            end else if (!in_frame) begin
                vectors++;
                if (sfs !== 1'b1 || sdata !== 1'b0 || underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL sync_cycle t=%0t got sfs=%b sdata=%b underrun=%b exp 1 0 0",
                             $time, sfs, sdata, underrun);
                end
                in_frame = 1'b1; cnt = 0; word = '0; und_first = 1'b0; und_extra = 1'b0;
            end else begin
                word = {word[FB-2:0], sdata};
                cnt++;
                if (cnt == 1) und_first = underrun;
                else if (underrun) und_extra = 1'b1;
                if (sfs || cnt == FB) begin
                    vectors++;
                    if (sfs !== 1'b1 || cnt != FB) begin
                        errors++;
                        $display("FAIL frame_length t=%0t got=%0d sfs=%b exp=%0d", $time, cnt,
                                 sfs, FB);
                    end
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_frame got=%h exp=none", word);
                    end else begin
                        e = exp_q.pop_front();
                        if (word !== e.w) begin
                            errors++;
                            $display("FAIL frame_word t=%0t got=%h exp=%h", $time, word, e.w);
                        end
                        vectors++;
                        if (und_first !== e.und || und_extra) begin
                            errors++;
                            $display("FAIL underrun_flag t=%0t got=%b extra=%b exp=%b", $time,
                                     und_first, und_extra, e.und);
                        end
                    end
                    cnt = 0; word = '0; und_first = 1'b0; und_extra = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #(100000 * 10);
        $display("FAIL watchdog got=no_finish exp=finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit            acc;
        logic [FB-1:0] nxt;
        logic [FB-1:0] pat;
        int            rate;
        bit            e;
        #2 rstn = 1'b0;
        #1 check_reset_outs("reset_values");
        repeat (3) @(negedge sclk);
        rstn = 1'b1;

        // Idle stream: SYNC, then IDLE_WORD frames each flagged as underrun.
        run(1'b1, 3 * FB + 2);
        stop_link();

        // Bypass: pattern offered only during the SYNC cycle goes straight into frame 0.
        pat = {32{8'hA5}};
        run(1'b1, 1);
        step(1'b1, 1'b1, pat, acc);
        run(1'b1, 2 * FB);

        // Back-to-back stream of words 1..10.
        nxt = 1;
        for (int i = 0; i < 12 * FB && nxt <= 10; i++) begin
            step(1'b1, 1'b1, nxt, acc);
            if (acc) nxt = nxt + 1;
        end
        // Source dries up; a late word offered mid-frame goes out the frame after.
        wait_k(1'b1, 3);
        wait_k(1'b1, FB / 2);
        offer(1'b1, rand_word());
        run(1'b1, 2 * FB);

        // Stop with a word buffered; it must lead the stream after restart.
        wait_k(1'b1, 10);
        offer(1'b0, rand_word());
        stop_link();
        run(1'b0, 5);
        run(1'b1, 2 * FB + 2);

        // Reset at k=100 with the hold buffer full; that word is discarded.
        wait_k(1'b1, 40);
        offer(1'b1, rand_word());
        wait_k(1'b1, 100);
        do_reset();
        run(1'b1, 2 * FB + 2);

        // Random traffic with varying offer rate and occasional en drops.
        rate = 50;
        e = 1'b1;
        for (int i = 0; i < 20 * FB; i++) begin
            if (i % 300 == 0) rate = $urandom_range(0, 100);
            if ($urandom_range(0, 499) == 0) e = !e;
            step(e, $urandom_range(0, 99) < rate, rand_word(), acc);
        end

        stop_link();
        run(1'b0, 4);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frames_outstanding got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
